// File: rtl/rl_lj_pair_arbiter_if.sv
// Bundle between the pair-filter lanes, the shared LJ force pipeline and
// the force accumulators; clk/rst stay plain ports on the arbiter.
//   enable, req_*          : lane requests (packed, lane i at [i*W +: W])
//   req_ready              : one-hot grant back to the lanes
//   pipe_r2_valid/pipe_*   : operands issued into the force pipeline
//   pipe_force_valid/fx..  : results coming back from the pipeline
//   out_*                  : result routed back with its {lane, pid} tag
//   inflight, err_misalign : status
interface rl_lj_pair_arbiter_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REQ      = 4,
    parameter int REQ_ID_WIDTH = 2,
    parameter int PID_WIDTH    = 8,
    parameter int PIPE_LATENCY = 14
);
    localparam int CNT_W = $clog2(PIPE_LATENCY + 2);

    logic                          enable;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_r2;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_dx;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_dy;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_dz;
    logic [NUM_REQ*PID_WIDTH-1:0]  req_pid;
    logic [NUM_REQ-1:0]            req_ready;

    logic                          pipe_r2_valid;
    logic [DATA_WIDTH-1:0]         pipe_r2;
    logic [DATA_WIDTH-1:0]         pipe_dx;
    logic [DATA_WIDTH-1:0]         pipe_dy;
    logic [DATA_WIDTH-1:0]         pipe_dz;
    logic                          pipe_force_valid;
    logic [DATA_WIDTH-1:0]         pipe_fx;
    logic [DATA_WIDTH-1:0]         pipe_fy;
    logic [DATA_WIDTH-1:0]         pipe_fz;

    logic                          out_valid;
    logic [REQ_ID_WIDTH-1:0]       out_req_id;
    logic [PID_WIDTH-1:0]          out_pid;
    logic [DATA_WIDTH-1:0]         out_fx;
    logic [DATA_WIDTH-1:0]         out_fy;
    logic [DATA_WIDTH-1:0]         out_fz;
    logic [CNT_W-1:0]              inflight;
    logic                          err_misalign;

    // arbiter side
    modport slave (
        input  enable, req_valid, req_r2, req_dx, req_dy, req_dz, req_pid,
        output req_ready,
        output pipe_r2_valid, pipe_r2, pipe_dx, pipe_dy, pipe_dz,
        input  pipe_force_valid, pipe_fx, pipe_fy, pipe_fz,
        output out_valid, out_req_id, out_pid, out_fx, out_fy, out_fz,
        output inflight, err_misalign
    );

    // environment side (lanes, pipeline, accumulators)
    modport master (
        output enable, req_valid, req_r2, req_dx, req_dy, req_dz, req_pid,
        input  req_ready,
        input  pipe_r2_valid, pipe_r2, pipe_dx, pipe_dy, pipe_dz,
        output pipe_force_valid, pipe_fx, pipe_fy, pipe_fz,
        input  out_valid, out_req_id, out_pid, out_fx, out_fy, out_fz,
        input  inflight, err_misalign
    );
endinterface

// File: rtl/rl_lj_pair_arbiter.sv
// Round-robin arbiter sharing one fixed-latency LJ force pipeline among
// NUM_REQ pair-filter lanes; a {lane, pid} tag chain routes results back.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rl_lj_pair_arbiter_if.slave (requests, pipeline, results)
module rl_lj_pair_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REQ      = 4,
    parameter int REQ_ID_WIDTH = 2,
    parameter int PID_WIDTH    = 8,
    parameter int PIPE_LATENCY = 14
) (
    input logic                  clk,
    input logic                  rst,
    rl_lj_pair_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(PIPE_LATENCY + 2);

    typedef struct packed {
        logic                    v;
        logic [REQ_ID_WIDTH-1:0] lane;
        logic [PID_WIDTH-1:0]    pid;
    } tag_t;

    logic [REQ_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                    gnt_found;
    logic [REQ_ID_WIDTH-1:0] gnt_idx;
    int                      scan_idx;
    logic                    xfer;
    logic [NUM_REQ-1:0]      ready;

    logic [DATA_WIDTH-1:0]   sel_r2, sel_dx, sel_dy, sel_dz;
    logic [PID_WIDTH-1:0]    sel_pid;

    logic                    iss_v_q, iss_v_d;
    logic [DATA_WIDTH-1:0]   iss_r2_q, iss_r2_d;
    logic [DATA_WIDTH-1:0]   iss_dx_q, iss_dx_d;
    logic [DATA_WIDTH-1:0]   iss_dy_q, iss_dy_d;
    logic [DATA_WIDTH-1:0]   iss_dz_q, iss_dz_d;
    logic [REQ_ID_WIDTH-1:0] iss_lane_q, iss_lane_d;
    logic [PID_WIDTH-1:0]    iss_pid_q, iss_pid_d;

    tag_t                    tag_q [PIPE_LATENCY];
    tag_t                    tag_d [PIPE_LATENCY];
    tag_t                    tail;

    logic                    out_valid_q, out_valid_d;
    logic [REQ_ID_WIDTH-1:0] out_id_q, out_id_d;
    logic [PID_WIDTH-1:0]    out_pid_q, out_pid_d;
    logic [DATA_WIDTH-1:0]   out_fx_q, out_fx_d;
    logic [DATA_WIDTH-1:0]   out_fy_q, out_fy_d;
    logic [DATA_WIDTH-1:0]   out_fz_q, out_fz_d;
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic                    err_q, err_d;

    // Scan lanes starting at rr_ptr, wrapping; first valid lane wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            if (!gnt_found && bus.req_valid[REQ_ID_WIDTH'(scan_idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = REQ_ID_WIDTH'(scan_idx);
            end
        end
    end

    // Ready is gated by rst too so nothing is accepted during reset.
    assign xfer = gnt_found & bus.enable & ~rst;

    always_comb begin
        ready = '0;
        if (xfer) ready[gnt_idx] = 1'b1;
    end

    assign bus.req_ready = ready;

    always_comb begin
        sel_r2  = '0;
        sel_dx  = '0;
        sel_dy  = '0;
        sel_dz  = '0;
        sel_pid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == REQ_ID_WIDTH'(i)) begin
                sel_r2  = bus.req_r2[i*DATA_WIDTH +: DATA_WIDTH];
                sel_dx  = bus.req_dx[i*DATA_WIDTH +: DATA_WIDTH];
                sel_dy  = bus.req_dy[i*DATA_WIDTH +: DATA_WIDTH];
                sel_dz  = bus.req_dz[i*DATA_WIDTH +: DATA_WIDTH];
                sel_pid = bus.req_pid[i*PID_WIDTH +: PID_WIDTH];
            end
        end
    end

    assign tail = tag_q[PIPE_LATENCY-1];

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        iss_v_d    = xfer;
        iss_r2_d   = iss_r2_q;
        iss_dx_d   = iss_dx_q;
        iss_dy_d   = iss_dy_q;
        iss_dz_d   = iss_dz_q;
        iss_lane_d = iss_lane_q;
        iss_pid_d  = iss_pid_q;
        if (xfer) begin
            rr_ptr_d   = (gnt_idx == REQ_ID_WIDTH'(NUM_REQ - 1)) ?
                         '0 : gnt_idx + REQ_ID_WIDTH'(1);
            iss_r2_d   = sel_r2;
            iss_dx_d   = sel_dx;
            iss_dy_d   = sel_dy;
            iss_dz_d   = sel_dz;
            iss_lane_d = gnt_idx;
            iss_pid_d  = sel_pid;
        end

        // Tag enters the chain while its operands sit on the pipe inputs,
        // so the tail lines up with pipe_force_valid.
        tag_d[0] = '{v: iss_v_q, lane: iss_lane_q, pid: iss_pid_q};
        for (int k = 1; k < PIPE_LATENCY; k++) tag_d[k] = tag_q[k-1];

        out_valid_d = tail.v & bus.pipe_force_valid;
        out_id_d    = tail.lane;
        out_pid_d   = tail.pid;
        out_fx_d    = bus.pipe_fx;
        out_fy_d    = bus.pipe_fy;
        out_fz_d    = bus.pipe_fz;
        err_d       = err_q | (tail.v ^ bus.pipe_force_valid);

        inflight_d = inflight_q;
        if (iss_v_q && !tail.v) inflight_d = inflight_q + CNT_W'(1);
        if (!iss_v_q && tail.v) inflight_d = inflight_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            iss_v_q     <= 1'b0;
            iss_r2_q    <= '0;
            iss_dx_q    <= '0;
            iss_dy_q    <= '0;
            iss_dz_q    <= '0;
            iss_lane_q  <= '0;
            iss_pid_q   <= '0;
            for (int k = 0; k < PIPE_LATENCY; k++) tag_q[k] <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_pid_q   <= '0;
            out_fx_q    <= '0;
            out_fy_q    <= '0;
            out_fz_q    <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            iss_v_q     <= iss_v_d;
            iss_r2_q    <= iss_r2_d;
            iss_dx_q    <= iss_dx_d;
            iss_dy_q    <= iss_dy_d;
            iss_dz_q    <= iss_dz_d;
            iss_lane_q  <= iss_lane_d;
            iss_pid_q   <= iss_pid_d;
            for (int k = 0; k < PIPE_LATENCY; k++) tag_q[k] <= tag_d[k];
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_pid_q   <= out_pid_d;
            out_fx_q    <= out_fx_d;
            out_fy_q    <= out_fy_d;
            out_fz_q    <= out_fz_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
        end
    end

    assign bus.pipe_r2_valid = iss_v_q;
    assign bus.pipe_r2       = iss_r2_q;
    assign bus.pipe_dx       = iss_dx_q;
    assign bus.pipe_dy       = iss_dy_q;
    assign bus.pipe_dz       = iss_dz_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_req_id    = out_id_q;
    assign bus.out_pid       = out_pid_q;
    assign bus.out_fx        = out_fx_q;
    assign bus.out_fy        = out_fy_q;
    assign bus.out_fz        = out_fz_q;
    assign bus.inflight      = inflight_q;
    assign bus.err_misalign  = err_q;
endmodule
